// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the add/sub arbiter slice.
// Mode encodings and the round-robin pointer advance live here.
package addsub_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/addsub_unit.sv
// Combinational WIDTH-bit adder/subtractor (subtract = A + ~B + 1).
// Overflow output exists only when ADDSUB_OVF_EN is defined.
module addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] w_b;

    always_comb begin
        w_b = b;
        unique case (m)
            ADD: w_b = b;
            SUB: w_b = ~b;
        endcase
    end

    // The mode bit doubles as the carry-in that completes the two's complement.
    assign {cout, s} = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, m};

`ifdef ADDSUB_OVF_EN
    assign ovf = (a[WIDTH-1] == w_b[WIDTH-1]) & (s[WIDTH-1] != a[WIDTH-1]);
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit among N_REQ requesters, with a
// single registered response slot. Define ADDSUB_OVF_EN to add the rsp_ovf output.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_m,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_s,
    output logic                   rsp_cout
`ifdef ADDSUB_OVF_EN
    ,
    output logic                   rsp_ovf
`endif
);

    logic             r_valid;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic [ID_W-1:0]  r_ptr;

    logic [ID_W-1:0]  w_grant;
    logic             w_found;
    logic             w_free;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_m;
    logic [WIDTH-1:0] w_s;
    logic             w_cout;
    int               w_dist;
    int               w_best;

    // Grant the valid requester closest to r_ptr going upward modulo N_REQ.
    always_comb begin
        w_grant = '0;
        w_best  = N_REQ;
        w_dist  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i - int'(r_ptr) + N_REQ) % N_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_grant = ID_W'(i);
            end
        end
        w_found = (w_best < N_REQ);
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        w_m = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
                w_m = req_m[i];
            end
        end
    end

    // Nothing is accepted while reset is asserted, even though the slot reads empty.
    assign w_free = rst_n & (~r_valid | rsp_ready);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = w_free & w_found & (w_grant == ID_W'(gi));
    end

    assign w_accept = |req_ready;

`ifdef ADDSUB_OVF_EN
    logic r_ovf;
    logic w_ovf;

    addsub_unit #(.WIDTH(WIDTH)) u_unit (
        .a    (w_a),
        .b    (w_b),
        .m    (w_m),
        .s    (w_s),
        .cout (w_cout),
        .ovf  (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_ovf;
        end
    end

    assign rsp_ovf = r_ovf;
`else
    addsub_unit #(.WIDTH(WIDTH)) u_unit (
        .a    (w_a),
        .b    (w_b),
        .m    (w_m),
        .s    (w_s),
        .cout (w_cout)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_id    <= w_grant;
            r_s     <= w_s;
            r_cout  <= w_cout;
            r_ptr   <= ID_W'(rr_next(int'(w_grant), N_REQ));
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_id    = r_id;
    assign rsp_s     = r_s;
    assign rsp_cout  = r_cout;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level arithmetic reference model.
module tb_addsub_arbiter;

    localparam int WIDTH = 4;
    localparam int N_REQ = 2;
    localparam int ID_W  = 1;
    localparam int MOD   = 1 << WIDTH;
    localparam int HALF  = MOD / 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a = '0;
    logic [N_REQ*WIDTH-1:0] req_b = '0;
    logic [N_REQ-1:0]       req_m = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_s;
    logic                   rsp_cout;
`ifdef ADDSUB_OVF_EN
    logic                   rsp_ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_valid = 0;
    int m_id = 0, m_s = 0, m_cout = 0, m_ovf = 0, m_ptr = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_m     (req_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout)
`ifdef ADDSUB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    function automatic void calc(input int a, input int b, input int m,
                                 output int s, output int cout, output int ovf);
        int full, sa, sb, sr;
        full = (m != 0) ? (a - b + MOD) : (a + b);
        s    = full % MOD;
        cout = (full >= MOD) ? 1 : 0;
        sa   = (a >= HALF) ? a - MOD : a;
        sb   = (b >= HALF) ? b - MOD : b;
        sr   = (m != 0) ? sa - sb : sa + sb;
        ovf  = (sr > HALF - 1 || sr < -HALF) ? 1 : 0;
    endfunction

    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_valid[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] model_ready();
        logic [N_REQ-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int g, s, c, o;
        bit rst_seen;
        s = 0; c = 0; o = 0;
        rst_seen = !rst_n;
        g = model_grant();
        if (g >= 0)
            calc(int'(req_a[g*WIDTH +: WIDTH]), int'(req_b[g*WIDTH +: WIDTH]),
                 int'(req_m[g]), s, c, o);
        @(posedge clk);
        #1;
        if (rst_seen) begin
            m_valid = 0; m_id = 0; m_s = 0; m_cout = 0; m_ovf = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1; m_id = g; m_s = s; m_cout = c; m_ovf = o;
            m_ptr = (g + 1) % N_REQ;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic set_op(input int i, input int a, input int b, input int m);
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        req_m[i] = (m != 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
        set_op(0, 0, 0, 0); set_op(1, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || rsp_s !== '0 || req_ready !== '0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: valid=%b s=%0d ready=%b, want 0/0/00",
                         c, rsp_valid, rsp_s, req_ready);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: ready=%b want 01", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_rsp: valid=%b id=%0d want 1/0", rsp_valid, rsp_id);
        end
        $display("test_reset done: valid=%b id=%0d", rsp_valid, rsp_id);
    endtask

    task automatic test_add();
        req_valid = 2'b01; rsp_ready = 1'b1;
        set_op(0, 7, 8, 0);
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_s !== 4'b1111 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL single_add: valid=%b id=%0d s=%0d cout=%b want 1/0/15/0",
                     rsp_valid, rsp_id, rsp_s, rsp_cout);
        end
        $display("test_add: 7+8 -> s=%0d cout=%b", rsp_s, rsp_cout);
    endtask

    task automatic test_sub();
        req_valid = 2'b10; rsp_ready = 1'b1;
        set_op(1, 4, 5, 1);
        tick();
        checks++;
        if (rsp_id !== 1'b1 || rsp_s !== 4'b1111 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL sub_4_5: id=%0d s=%0d cout=%b want 1/15/0", rsp_id, rsp_s, rsp_cout);
        end
`ifdef ADDSUB_OVF_EN
        checks++;
        if (rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_4_5_ovf: ovf=%b want 0", rsp_ovf);
        end
`endif
        $display("test_sub: 4-5 -> s=%0d cout=%b", rsp_s, rsp_cout);
        set_op(1, 4, 4, 1);
        tick();
        checks++;
        if (rsp_s !== 4'b0000 || rsp_cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_4_4: s=%0d cout=%b want 0/1", rsp_s, rsp_cout);
        end
        $display("test_sub: 4-4 -> s=%0d cout=%b", rsp_s, rsp_cout);
    endtask

    task automatic test_contention();
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(0, $urandom_range(0, MOD-1), $urandom_range(0, MOD-1), $urandom_range(0, 1));
            set_op(1, $urandom_range(0, MOD-1), $urandom_range(0, MOD-1), $urandom_range(0, 1));
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(k % 2) || rsp_s !== WIDTH'(m_s)
                || rsp_cout !== m_cout[0]) begin
                errors++;
                $display("FAIL contention_%0d: valid=%b id=%0d s=%0d cout=%b want 1/%0d/%0d/%0d",
                         k, rsp_valid, rsp_id, rsp_s, rsp_cout, k % 2, m_s, m_cout);
            end
            $display("contention %0d: id=%0d s=%0d", k, rsp_id, rsp_s);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] s0;
        logic [ID_W-1:0]  id0;
        logic             c0;
        s0 = rsp_s; id0 = rsp_id; c0 = rsp_cout;
        rsp_ready = 1'b0; req_valid = 2'b11;
        set_op(0, 3, 9, 0); set_op(1, 12, 2, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL bp_ready_%0d: ready=%b want 00", k, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_s !== s0 || rsp_id !== id0 || rsp_cout !== c0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b s=%0d id=%0d cout=%b want 1/%0d/%0d/%b",
                         k, rsp_valid, rsp_s, rsp_id, rsp_cout, s0, id0, c0);
            end
            $display("backpressure %0d: held s=%0d id=%0d", k, rsp_s, rsp_id);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_release_ready: ready=%b want 01", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_s !== 4'd12 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_rsp: valid=%b id=%0d s=%0d cout=%b want 1/0/12/0",
                     rsp_valid, rsp_id, rsp_s, rsp_cout);
        end
        $display("backpressure release: id=%0d s=%0d", rsp_id, rsp_s);
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0; req_valid = 2'b11; rst_n = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_s !== '0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b s=%0d id=%0d want 0/0/0", rsp_valid, rsp_s, rsp_id);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: valid=%b id=%0d want 1/0", rsp_valid, rsp_id);
        end
        $display("test_reset_mid: valid=%b id=%0d", rsp_valid, rsp_id);
    endtask

    task automatic test_overflow();
        rsp_ready = 1'b1; req_valid = 2'b01;
        set_op(0, 7, 1, 0);
        tick();
        checks++;
        if (rsp_s !== 4'b1000 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sum: s=%0d cout=%b want 8/0", rsp_s, rsp_cout);
        end
`ifdef ADDSUB_OVF_EN
        checks++;
        if (rsp_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b want 1", rsp_ovf);
        end
`endif
        $display("test_overflow: 7+1 -> s=%0d", rsp_s);
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] exp_ready;
        int bad;
        for (int k = 0; k < 300; k++) begin
            req_valid = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_REQ; i++)
                set_op(i, $urandom_range(0, MOD-1), $urandom_range(0, MOD-1), $urandom_range(0, 1));
            #1;
            exp_ready = model_ready();
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready_%0d: ready=%b want %b", k, req_ready, exp_ready);
            end
            tick();
            bad = 0;
            if (rsp_valid !== m_valid || rsp_id !== ID_W'(m_id) || rsp_s !== WIDTH'(m_s)
                || rsp_cout !== m_cout[0]) bad = 1;
`ifdef ADDSUB_OVF_EN
            if (rsp_ovf !== m_ovf[0]) bad = 1;
`endif
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_rsp_%0d: valid=%b id=%0d s=%0d cout=%b want %0d/%0d/%0d/%0d",
                         k, rsp_valid, rsp_id, rsp_s, rsp_cout, m_valid, m_id, m_s, m_cout);
            end
            $display("rand %0d: valid=%b id=%0d s=%0d cout=%b", k, rsp_valid, rsp_id, rsp_s, rsp_cout);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
